// File: rtl/wb_regfile.sv
// Writeback-stage register file: 31 x 32-bit GPRs with load extension, write-through
// bypass on both read ports and a 64-bit retired-instruction counter.
module wb_regfile #(
  parameter logic [31:0] SP_INIT       = 32'h0000_0000,
  parameter int unsigned COUNT_BUBBLES = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] inst_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] read_data_in,
  input  logic [1:0]  RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [63:0] instret
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [63:0] instret_q;
  logic [63:0] instret_d;
  logic        bypass_en_s;

  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  offset,
                                              input logic [31:0] word);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    case (offset)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    half_s = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  res_s = {24'h00_0000, byte_s};
      3'b001:  res_s = {{16{half_s[15]}}, half_s};
      3'b101:  res_s = {16'h0000, half_s};
      default: res_s = word;
    endcase
    return res_s;
  endfunction

  assign wb_we       = (RegWrite_in != 2'b00) && (rd_in != 5'd0);
  assign wb_rd       = wb_we ? rd_in : 5'd0;
  assign instret     = instret_q;
  // No bypass while in reset so the ports show the cleared contents.
  assign bypass_en_s = wb_we && rst;

  // Writeback value select
  always_comb begin
    wb_data = alures_in;
    case (MemtoReg_in)
      2'b00:   wb_data = alures_in;
      2'b01:   wb_data = load_extend(inst_in[14:12], alures_in[1:0], read_data_in);
      2'b10:   wb_data = PC_in + 32'd4;
      default: wb_data = alures_in;
    endcase
  end

  // Next-state for the register array and retire counter
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      if (wb_we && (rd_in == 5'(i))) begin
        regs_d[i] = wb_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    if ((inst_in != 32'd0) || (COUNT_BUBBLES != 32'd0)) begin
      instret_d = instret_q + 64'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Read port 1 with write-through bypass
  always_comb begin
    rs1_data = 32'd0;
    if (rs1_addr == 5'd0) begin
      rs1_data = 32'd0;
    end else if (bypass_en_s && (rs1_addr == rd_in)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2 with write-through bypass
  always_comb begin
    rs2_data = 32'd0;
    if (rs2_addr == 5'd0) begin
      rs2_data = 32'd0;
    end else if (bypass_en_s && (rs2_addr == rd_in)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // State registers; async reset overrides any same-edge write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? SP_INIT : 32'd0;
      end
      instret_q <= 64'd0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expectations into a scoreboard,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_regfile;

  localparam logic [31:0] SP = 32'hDEAD_BEE0;
  localparam int S_RS1 = 0, S_RS2 = 1, S_WBD = 2, S_WBRD = 3, S_WBWE = 4, S_INSTRET = 5;

  logic        clk, rst;
  logic [31:0] PC_in, inst_in, alures_in, read_data_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic [1:0]  RegWrite_in, MemtoReg_in;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [63:0] instret;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit done_s = 1'b0;
  string       name_q[$];
  int          sel_q[$];
  logic [63:0] exp_q[$];

  wb_regfile #(.SP_INIT(SP), .COUNT_BUBBLES(0)) dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .inst_in(inst_in), .rd_in(rd_in),
    .alures_in(alures_in), .read_data_in(read_data_in), .RegWrite_in(RegWrite_in),
    .MemtoReg_in(MemtoReg_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string n, input int s, input logic [63:0] e);
    name_q.push_back(n);
    sel_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string n, input int s, input logic [63:0] e);
    logic [63:0] a;
    case (s)
      S_RS1:     a = {32'd0, rs1_data};
      S_RS2:     a = {32'd0, rs2_data};
      S_WBD:     a = {32'd0, wb_data};
      S_WBRD:    a = {59'd0, wb_rd};
      S_WBWE:    a = {63'd0, wb_we};
      default:   a = instret;
    endcase
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s (direct): got %h, expected %h", n, a, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_in = 2'b00; MemtoReg_in = 2'b00; inst_in = 32'd0; rd_in = 5'd0;
    alures_in = 32'd0; read_data_in = 32'd0; PC_in = 32'd0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [1:0] m2r, input logic [31:0] inst,
                    input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc);
    RegWrite_in = 2'b01; MemtoReg_in = m2r; inst_in = inst; rd_in = rd;
    alures_in = alu; read_data_in = rdata; PC_in = pc;
  endtask

  // Watchdog: report a failure if the stimulus never completes
  initial begin
    #100000;
    if (!done_s) begin
      total_cnt++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
    end
  end

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      string       n;
      int          s;
      logic [63:0] e, a;
      n = name_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      case (s)
        S_RS1:     a = {32'd0, rs1_data};
        S_RS2:     a = {32'd0, rs2_data};
        S_WBD:     a = {32'd0, wb_data};
        S_WBRD:    a = {59'd0, wb_rd};
        S_WBWE:    a = {63'd0, wb_we};
        default:   a = instret;
      endcase
      total_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  end

  logic [2:0]  ld_f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b110};
  logic [1:0]  ld_off [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
  logic [31:0] ld_exp [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                              32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
  logic        inst_pat [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    idle();
    cyc();
    rs1_addr = 5'd2;
    rs2_addr = 5'd2;
    #1;
    chk("instret_in_reset", S_INSTRET, 64'd0);
    chk("x2_in_reset", S_RS1, {32'd0, SP});
    chk("x2_in_reset_sp", S_RS2, {32'd0, SP});
    rs1_addr = 5'd0;
    #1;
    chk("x0_in_reset", S_RS1, 64'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // Reset contents of all 32 indices on both ports
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      push("reset_rs1", S_RS1, (i == 2) ? {32'd0, SP} : 64'd0);
      push("reset_rs2", S_RS2, ((31 - i) == 2) ? {32'd0, SP} : 64'd0);
      cyc();
    end

    // ALU write with same-cycle bypass on both ports
    wr(5'd5, 2'b00, 32'h0000_0033, 32'h1234_5678, 32'd0, 32'd0);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    push("alu_bypass_rs1", S_RS1, 64'h1234_5678);
    push("alu_bypass_rs2", S_RS2, 64'h1234_5678);
    push("alu_wb_we", S_WBWE, 64'd1);
    push("alu_wb_rd", S_WBRD, 64'd5);
    cyc();
    idle();
    push("x5_stored", S_RS1, 64'h1234_5678);
    push("instret_after_1", S_INSTRET, 64'd1);
    cyc();

    // Load extension variants into x10..x16
    for (int k = 0; k < 7; k++) begin
      wr(5'(10 + k), 2'b01, {17'd0, ld_f3[k], 12'h003}, {30'h0000_4000, ld_off[k]},
         32'h80FF_7F01, 32'd0);
      push("load_wb_data", S_WBD, {32'd0, ld_exp[k]});
      cyc();
    end
    idle();
    for (int k = 0; k < 7; k++) begin
      rs1_addr = 5'(10 + k);
      push("load_stored", S_RS1, {32'd0, ld_exp[k]});
      cyc();
    end

    // JAL link values, PC wrap, and write to x0
    wr(5'd1, 2'b10, 32'h0000_006F, 32'h0000_0999, 32'd0, 32'h0000_0100);
    push("jal_wb_data", S_WBD, 64'h0000_0104);
    cyc();
    wr(5'd3, 2'b10, 32'h0000_006F, 32'h0000_0999, 32'd0, 32'hFFFF_FFFC);
    rs1_addr = 5'd3;
    push("jal_pc_wrap", S_RS1, 64'd0);
    cyc();
    wr(5'd0, 2'b00, 32'h0000_0013, 32'hDEAD_BEEF, 32'd0, 32'd0);
    rs1_addr = 5'd0;
    push("x0_wb_we", S_WBWE, 64'd0);
    push("x0_wb_rd", S_WBRD, 64'd0);
    push("x0_read", S_RS1, 64'd0);
    cyc();
    idle();
    rs1_addr = 5'd1; rs2_addr = 5'd0;
    push("x1_link", S_RS1, 64'h0000_0104);
    push("x0_still_zero", S_RS2, 64'd0);
    push("instret_after_11", S_INSTRET, 64'd11);
    cyc();

    // 10 instructions mixed with 3 bubbles
    for (int k = 0; k < 13; k++) begin
      inst_in = inst_pat[k] ? 32'h0000_0013 : 32'd0;
      cyc();
    end
    idle();
    push("instret_after_21", S_INSTRET, 64'd21);
    cyc();

    // Counter wrap from all-ones
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    push("instret_preload", S_INSTRET, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    #1;
    release dut.instret_q;
    cyc();
    inst_in = 32'h0000_0013;
    cyc();
    idle();
    push("instret_wrap", S_INSTRET, 64'd0);
    cyc();

    // Async reset in the middle of a write stream
    wr(5'd7, 2'b00, 32'h0000_0033, 32'hA5A5_A5A5, 32'd0, 32'd0);
    cyc();
    wr(5'd7, 2'b00, 32'h0000_0033, 32'h1111_1111, 32'd0, 32'd0);
    rs1_addr = 5'd7; rs2_addr = 5'd2;
    #2;
    rst = 1'b0;
    push("async_clr_x7", S_RS1, 64'd0);
    push("async_x2_sp", S_RS2, {32'd0, SP});
    push("async_instret", S_INSTRET, 64'd0);
    cyc();
    push("reset_blocks_write", S_RS1, 64'd0);
    push("reset_blocks_count", S_INSTRET, 64'd0);
    cyc();

    // Reset asserted on the same edge as a pending write
    rst = 1'b1;
    wr(5'd8, 2'b00, 32'h0000_0033, 32'h2222_2222, 32'd0, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    #1;
    idle();
    rs1_addr = 5'd8;
    push("same_edge_reset_x8", S_RS1, 64'd0);
    cyc();

    // First clock after reset release accepts a write
    rst = 1'b1;
    wr(5'd9, 2'b00, 32'h0000_0033, 32'h3333_3333, 32'd0, 32'd0);
    cyc();
    idle();
    rs1_addr = 5'd9; rs2_addr = 5'd8;
    push("first_write_x9", S_RS1, 64'h3333_3333);
    push("x8_unwritten", S_RS2, 64'd0);
    push("instret_first", S_INSTRET, 64'd1);
    cyc();
    cyc();

    done_s = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'h0000_0000, reset value of register x2.
REQ-002 SHALL have parameter COUNT_BUBBLES, default 0; 1 = all-zero instructions also increment instret.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 PC_in  input  32  PC of the instruction in writeback.
REQ-006 inst_in  input  32  instruction word in writeback; 32'h0 = bubble.
REQ-007 rd_in  input  5  destination register index.
REQ-008 alures_in  input  32  ALU result / memory address.
REQ-009 read_data_in  input  32  raw aligned memory word.
REQ-010 RegWrite_in  input  2  write enable; any nonzero value = write.
REQ-011 MemtoReg_in  input  2  source select: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-012 rs1_addr, rs2_addr  input  5 each  read-port indices from decode.
REQ-013 rs1_data, rs2_data  output  32 each  read-port data.
REQ-014 wb_data  output  32  selected writeback value (combinational).
REQ-015 wb_rd  output  5  rd_in, forced to 0 when wb_we=0.
REQ-016 wb_we  output  1  effective write enable, for the forwarding unit.
REQ-017 instret  output  64  retired-instruction counter.

Function
REQ-018 Storage: 31 registers x1..x31, 32 bits each; x0 SHALL read 0 and never be written.
REQ-019 wb_we = (RegWrite_in != 0) && (rd_in != 0).
REQ-020 On rising clk with wb_we=1, register[rd_in] <= wb_data; one write per cycle.
REQ-021 Load extension: funct3 = inst_in[14:12], offset = alures_in[1:0].
REQ-022 funct3 000 (LB): byte lane offset, sign-extended; 100 (LBU): same byte, zero-extended.
REQ-023 funct3 001 (LH): halfword lane alures_in[1], sign-extended; 101 (LHU): zero-extended; alures_in[0] ignored.
REQ-024 funct3 010 and all other codes: full read_data_in unchanged.
REQ-025 MemtoReg 10: wb_data = PC_in + 4, modulo 2^32 (PC 32'hFFFF_FFFC yields 0).
REQ-026 Read ports combinational; address 0 returns 0.
REQ-027 Write-through bypass: if wb_we=1 and raddr == rd_in, that port SHALL return wb_data in the same cycle.
REQ-028 Both read ports SHALL bypass independently, including rs1_addr == rs2_addr == rd_in.
REQ-029 instret increments by 1 per clk when inst_in != 0, or on every clk if COUNT_BUBBLES=1.
REQ-030 instret SHALL wrap from 2^64-1 to 0 with no flag.
REQ-031 RegWrite_in nonzero with rd_in=0 (e.g. NOP): no state change except instret.

Reset
REQ-032 rst=0 SHALL immediately clear x1..x31 to 0 except x2=SP_INIT, and clear instret to 0.
REQ-033 While rst=0, writes and counting are suppressed; read ports still reflect the reset contents.
REQ-034 First write is accepted on the first rising clk with rst=1.
REQ-035 Reset asserted mid-write (same edge) SHALL win; the register holds its reset value.

Verification
REQ-036 Reset then read all 32 indices -> all 0 except x2 = SP_INIT.
REQ-037 RegWrite=01, MemtoReg=00, rd=5, alures=32'h1234_5678 -> same cycle: rs1_addr=5 reads 32'h1234_5678 (bypass); next cycle: x5 reads 32'h1234_5678.
REQ-038 Load with read_data=32'h80FF_7F01 -> results per encoding:
  LB, offset 3 -> 32'hFFFF_FF80
  LBU, offset 3 -> 32'h0000_0080
  LH, offset 2 -> 32'hFFFF_80FF
  LHU, offset 0 -> 32'h0000_7F01
  LW -> 32'h80FF_7F01
REQ-039 JAL writeback, MemtoReg=10, PC=32'h0000_0100, rd=1 -> x1 = 32'h0000_0104; write to rd=0 -> x0 still reads 0, wb_we=0, wb_rd=0.
REQ-040 Feed 10 instructions plus 3 bubbles (COUNT_BUBBLES=0) -> instret=10; preload 64'hFFFF_FFFF_FFFF_FFFF -> next retire gives 0.
REQ-041 Assert rst mid-write stream -> registers cleared asynchronously, before the next clk edge; no pending write lands.
